// File: rtl/ride_stage_tracker.sv
// Ride state tracker: turns the driver's start/end strobes and the wheel-sensor
// distance strobe into ride state, accumulated distance, one-hot tariff stage
// and a stopping flag for the downstream wait meter.
module ride_stage_tracker #(
    parameter int unsigned   DW           = 32,
    parameter logic [DW-1:0] STAGE2_DIST  = DW'(30),
    parameter logic [DW-1:0] STAGE3_DIST  = DW'(100),
    parameter logic [DW-1:0] STOP_TIMEOUT = DW'(50)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ride_start,
    input  logic          ride_end,
    input  logic          wheel_pulse,
    output logic          riding,
    output logic [DW-1:0] distance,
    output logic          is_stage_1st,
    output logic          is_stage_2nd,
    output logic          is_stage_3rd,
    output logic          stopping
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e        state_q;
    logic [DW-1:0] distance_q;
    logic [DW-1:0] gap_q;

    // Ride FSM together with the distance and pulse-gap counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            distance_q <= '0;
            gap_q      <= '0;
        end else begin
            case (state_q)
                StIdle, StHold: begin
                    // ride_start beats a simultaneous ride_end here.
                    if (ride_start) begin
                        state_q    <= StRun;
                        distance_q <= '0;
                        gap_q      <= '0;
                    end
                end
                StRun: begin
                    if (ride_end) begin
                        // Distance frozen; a coincident pulse is dropped.
                        state_q <= StHold;
                        gap_q   <= '0;
                    end else if (ride_start) begin
                        // Restart: a coincident pulse is dropped.
                        distance_q <= '0;
                        gap_q      <= '0;
                    end else if (wheel_pulse) begin
                        if (distance_q != '1) begin
                            distance_q <= distance_q + DW'(1);
                        end
                        gap_q <= '0;
                    end else if (gap_q < STOP_TIMEOUT) begin
                        gap_q <= gap_q + DW'(1);
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    distance_q <= '0;
                    gap_q      <= '0;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        riding       = (state_q == StRun);
        stopping     = (state_q == StRun) && (gap_q == STOP_TIMEOUT);
        distance     = distance_q;
        is_stage_1st = 1'b0;
        is_stage_2nd = 1'b0;
        is_stage_3rd = 1'b0;
        if (state_q != StIdle) begin
            if (distance_q >= STAGE3_DIST) begin
                is_stage_3rd = 1'b1;
            end else if (distance_q >= STAGE2_DIST) begin
                is_stage_2nd = 1'b1;
            end else begin
                is_stage_1st = 1'b1;
            end
        end
    end

endmodule
